// File: rtl/video_pkg.sv
// Shared mode encoding, controller state set and sizing helper for the video mode controller.
package video_pkg;

    typedef enum logic [1:0] {
        VMODE_OFF  = 2'd0,
        VMODE_640  = 2'd1,
        VMODE_1024 = 2'd2,
        VMODE_1280 = 2'd3
    } vmode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SWITCH,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN_UP
    } vstate_e;

    // Cycles after a PLL reprogram during which its lock flag is not trusted.
    localparam int unsigned LOCK_IGNORE_CYCLES = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/video_mode_ctrl.sv
// Sequences video mode changes: blank, reprogram the clock, wait for a stable PLL lock,
// release the pipeline reset, then re-enable pixel output. Also recovers from loss of lock.
module video_mode_ctrl
    import video_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 96_000_000,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned SETTLE_DELAY = CLK_FREQ / 1000,
    parameter int unsigned LOCK_TIMEOUT = CLK_FREQ / 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    input  logic       pll_locked,
    output logic [1:0] video_mode,
    output logic       video_reset,
    output logic       video_enable,
    output logic       busy,
    output logic       lock_error
);

    localparam int unsigned CNT_MAX = max3(DRAIN_CYCLES, SETTLE_DELAY, LOCK_TIMEOUT);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IGNORE_CNT   = CNT_W'(LOCK_IGNORE_CYCLES);

    vstate_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    vmode_e           target_q, target_d;
    vmode_e           video_mode_q, video_mode_d;
    logic             video_reset_q, video_reset_d;
    logic             video_enable_q, video_enable_d;
    logic             lock_error_q, lock_error_d;
    logic             lock_s;
    logic             req_accept;
    logic             lost_lock;

    sync_2ff u_lock_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    assign req_accept = req_valid && (state_q == ST_IDLE);
    assign lost_lock  = (video_mode_q != VMODE_OFF) && !video_reset_q && !lock_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            target_q       <= VMODE_OFF;
            video_mode_q   <= VMODE_OFF;
            video_reset_q  <= 1'b1;
            video_enable_q <= 1'b0;
            lock_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            video_mode_q   <= video_mode_d;
            video_reset_q  <= video_reset_d;
            video_enable_q <= video_enable_d;
            lock_error_q   <= lock_error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    target_d = vmode_e'(req_mode);
                    if ((vmode_e'(req_mode) != video_mode_q) || lock_error_q) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end
                end
                if ((state_d == ST_IDLE) && lost_lock) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_SWITCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SWITCH: begin
                state_d = (target_q == VMODE_OFF) ? ST_IDLE : ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if ((cnt_q >= IGNORE_CNT) && lock_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN_UP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        video_mode_d   = video_mode_q;
        video_reset_d  = video_reset_q;
        video_enable_d = video_enable_q;
        lock_error_d   = lock_error_q;
        req_ready      = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    lock_error_d = 1'b0;
                end
                if (state_d == ST_BLANK) begin
                    video_enable_d = 1'b0;
                end else if (state_d == ST_WAIT_LOCK) begin
                    video_enable_d = 1'b0;
                    video_reset_d  = 1'b1;
                end else if ((video_mode_q != VMODE_OFF) && !video_reset_q) begin
                    video_enable_d = 1'b1;
                end
            end
            ST_BLANK: begin
                video_enable_d = 1'b0;
                // Registered on the edge into SWITCH so the new mode is presented during SWITCH.
                if (state_d == ST_SWITCH) begin
                    video_mode_d  = target_q;
                    video_reset_d = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (state_d == ST_IDLE) begin
                    lock_error_d   = 1'b1;
                    video_reset_d  = 1'b1;
                    video_enable_d = 1'b0;
                end
            end
            ST_RUN_UP: begin
                video_reset_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign video_mode   = video_mode_q;
    assign video_reset  = video_reset_q;
    assign video_enable = video_enable_q;
    assign lock_error   = lock_error_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: a per-cycle behavioural model plus literal timing checks.
module tb_video_mode_ctrl;

    localparam int unsigned DRAIN   = 4;
    localparam int unsigned SETTLE  = 8;
    localparam int unsigned TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic       pll_locked;
    logic [1:0] video_mode;
    logic       video_reset;
    logic       video_enable;
    logic       busy;
    logic       lock_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_on = 1'b0;

    video_mode_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .SETTLE_DELAY (SETTLE),
        .LOCK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .pll_locked   (pll_locked),
        .video_mode   (video_mode),
        .video_reset  (video_reset),
        .video_enable (video_enable),
        .busy         (busy),
        .lock_error   (lock_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: phase plus cycles spent in it, lock seen through two sample delays.
    typedef enum {M_QUIET, M_DRAIN, M_APPLY, M_ACQUIRE, M_HOLD, M_RELEASE} mphase_e;
    mphase_e    ph;
    int         spent;
    logic [1:0] m_tgt;
    logic [1:0] e_mode;
    logic       e_rst, e_en, e_err;
    logic [1:0] lk;

    always @(posedge clk) begin : model
        logic lock_now;
        logic moved;
        if (reset) begin
            ph = M_QUIET; spent = 0; m_tgt = 2'd0; e_mode = 2'd0;
            e_rst = 1'b1; e_en = 1'b0; e_err = 1'b0; lk = 2'b00;
        end else begin
            lock_now = lk[1];
            lk = {lk[0], pll_locked};
            spent++;
            case (ph)
                M_QUIET: begin
                    moved = 1'b0;
                    if (req_valid) begin
                        m_tgt = req_mode;
                        if (req_mode != e_mode || e_err) begin
                            ph = M_DRAIN; spent = 0; e_en = 1'b0; moved = 1'b1;
                        end
                        e_err = 1'b0;
                    end
                    if (!moved && e_mode != 2'd0 && !e_rst) begin
                        if (!lock_now) begin
                            ph = M_ACQUIRE; spent = 0; e_en = 1'b0; e_rst = 1'b1;
                        end else begin
                            e_en = 1'b1;
                        end
                    end
                end
                M_DRAIN: if (spent == DRAIN) begin
                    ph = M_APPLY; spent = 0; e_mode = m_tgt; e_rst = 1'b1;
                end
                M_APPLY: begin
                    ph = (m_tgt == 2'd0) ? M_QUIET : M_ACQUIRE; spent = 0;
                end
                M_ACQUIRE: begin
                    if (spent > 4 && lock_now) begin
                        ph = M_HOLD; spent = 0;
                    end else if (spent == TIMEOUT) begin
                        ph = M_QUIET; spent = 0; e_err = 1'b1; e_rst = 1'b1; e_en = 1'b0;
                    end
                end
                M_HOLD: begin
                    if (!lock_now) begin
                        ph = M_ACQUIRE; spent = 0;
                    end else if (spent == SETTLE) begin
                        ph = M_RELEASE; spent = 0;
                    end
                end
                M_RELEASE: begin
                    ph = M_QUIET; spent = 0; e_rst = 1'b0;
                end
                default: ph = M_QUIET;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("mdl_video_mode", 32'(video_mode), 32'(e_mode));
            chk("mdl_video_reset", 32'(video_reset), 32'(e_rst));
            chk("mdl_video_enable", 32'(video_enable), 32'(e_en));
            chk("mdl_lock_error", 32'(lock_error), 32'(e_err));
            chk("mdl_busy", 32'(busy), 32'(ph != M_QUIET));
            chk("mdl_req_ready", 32'(req_ready), 32'(ph == M_QUIET));
        end
    end

    task automatic wait_cycle(input int k);
        for (int i = 0; i < 2000 && cyc < k; i++) @(negedge clk);
    endtask

    task automatic request(input logic [1:0] m, output int acc);
        acc = -1;
        req_mode  = m;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("req_ack_seen", 32'(acc >= 0), 32'd1);
        if (acc < 0) acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("idle_reached", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc;
        int c;
        reset = 1'b1; req_valid = 1'b0; req_mode = 2'd0; pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_mode", 32'(video_mode), 32'd0);
        chk("rst_vreset", 32'(video_reset), 32'd1);
        chk("rst_enable", 32'(video_enable), 32'd0);
        chk("rst_lock_error", 32'(lock_error), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Mode 3 with lock held: mode on SWITCH, reset low 20 cycles after accept, enable one later
        request(2'd3, acc);
        wait_cycle(acc + 4);  chk("m3_mode_pre", 32'(video_mode), 32'd0);
        wait_cycle(acc + 5);  chk("m3_mode_switch", 32'(video_mode), 32'd3);
        wait_cycle(acc + 19); chk("m3_vreset_hold", 32'(video_reset), 32'd1);
        wait_cycle(acc + 20); chk("m3_vreset_fall", 32'(video_reset), 32'd0);
        chk("m3_enable_pre", 32'(video_enable), 32'd0);
        wait_cycle(acc + 21); chk("m3_enable_rise", 32'(video_enable), 32'd1);
        wait_idle();

        // Running mode change to 1: blank at once without resetting the pipeline yet
        request(2'd1, acc);
        wait_cycle(acc + 1);
        chk("m1_blank_en", 32'(video_enable), 32'd0);
        chk("m1_blank_rst", 32'(video_reset), 32'd0);
        wait_idle();

        // Same-mode request while running: immediate ack, outputs untouched
        c = cyc;
        request(2'd1, acc);
        chk("same_ack_cycle", 32'(acc), 32'(c));
        wait_cycle(acc + 3);
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_enable", 32'(video_enable), 32'd1);
        chk("same_mode", 32'(video_mode), 32'd1);

        // Loss of lock for 3 cycles while running mode 1
        c = cyc;
        pll_locked = 1'b0;
        wait_cycle(c + 2);  chk("lol_en_still", 32'(video_enable), 32'd1);
        wait_cycle(c + 3);
        chk("lol_en_drop", 32'(video_enable), 32'd0);
        chk("lol_rst_set", 32'(video_reset), 32'd1);
        pll_locked = 1'b1;
        wait_cycle(c + 17);
        chk("lol_rst_fall", 32'(video_reset), 32'd0);
        chk("lol_en_pre", 32'(video_enable), 32'd0);
        wait_cycle(c + 18); chk("lol_en_rise", 32'(video_enable), 32'd1);
        chk("lol_mode_kept", 32'(video_mode), 32'd1);
        repeat (2) @(negedge clk);

        // Mode 2 with no lock: timeout after 32 WAIT_LOCK cycles
        pll_locked = 1'b0;
        request(2'd2, acc);
        wait_cycle(acc + 5);  chk("to_mode", 32'(video_mode), 32'd2);
        wait_cycle(acc + 37); chk("to_err_pre", 32'(lock_error), 32'd0);
        wait_cycle(acc + 38);
        chk("to_err_set", 32'(lock_error), 32'd1);
        chk("to_vreset", 32'(video_reset), 32'd1);
        chk("to_enable", 32'(video_enable), 32'd0);
        chk("to_ready", 32'(req_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("to_err_sticky", 32'(lock_error), 32'd1);

        // Same mode after an error is a full retry and clears the flag
        pll_locked = 1'b1;
        request(2'd2, acc);
        wait_cycle(acc + 1);
        chk("retry_busy", 32'(busy), 32'd1);
        chk("retry_err_clr", 32'(lock_error), 32'd0);
        wait_idle();

        // Mode 0 from running: ends idle in reset without waiting for lock
        request(2'd0, acc);
        wait_cycle(acc + 5);
        chk("off_mode", 32'(video_mode), 32'd0);
        chk("off_vreset", 32'(video_reset), 32'd1);
        wait_cycle(acc + 6); chk("off_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Reset during SETTLE, then mode 0 request with no lock
        request(2'd1, acc);
        wait_cycle(acc + 13); chk("settle_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        wait_cycle(acc + 14);
        chk("ab_mode", 32'(video_mode), 32'd0);
        chk("ab_vreset", 32'(video_reset), 32'd1);
        chk("ab_enable", 32'(video_enable), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        pll_locked = 1'b0;
        @(negedge clk);
        c = cyc;
        request(2'd0, acc);
        chk("off2_ack", 32'(acc), 32'(c));
        wait_cycle(acc + 1);  chk("off2_busy", 32'(busy), 32'd0);
        wait_cycle(acc + 40);
        chk("off2_vreset", 32'(video_reset), 32'd1);
        chk("off2_mode", 32'(video_mode), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
